led_flow_monitor: RTL and testbench

Receive-side checker for the 4-bit active-low running-light pattern driven by the LED flow generator. It synchronises the pattern and rejects glitches with a stability filter. It then decodes the one-cold code into a position and tracks the rotation order 0→1→2→3→0. Use it for board loop-back self-test and for link checking between boards.

---
 rtl/led_flow_monitor.sv | 180 ++++++++++++++++++
 tb/tb_led_flow_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_flow_monitor.sv
// Receive-side checker for the active-low one-cold LED running light: synchronise, debounce, decode, track rotation.
// Outputs update STABLE_CYCLES+3 clocks after a new pattern is first sampled; there is no backpressure.
module led_flow_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int LOCK_STEPS    = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           led_in,
  input  logic                 clr_cnt,
  output logic [1:0]           pos,
  output logic                 pos_valid,
  output logic                 locked,
  output logic                 step_pulse,
  output logic                 seq_err,
  output logic                 code_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int STRK_W = $clog2(LOCK_STEPS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [STRK_W-1:0] STRK_LOCK = STRK_W'(LOCK_STEPS);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  logic [3:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]           cand_q, cand_d, acc_q, acc_d, code_q, code_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 evt_q, evt_d;
  state_e               state_q, state_d;
  logic [1:0]           last_q, last_d, pos_q, pos_d;
  logic                 last_v_q, last_v_d, pos_valid_q, pos_valid_d;
  logic [STRK_W-1:0]    streak_q, streak_d;
  logic                 step_q, step_d, seq_q, seq_d, code_err_q, code_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [1:0] dec_pos;
  logic [1:0] next_last;
  logic       is_pos, is_idle;

  // Synchroniser and stability filter; the accepted code is registered once more before the FSM sees it.
  always_comb begin
    sync1_d = led_in;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    evt_d  = (cnt_q == CNT_MAX) && (cand_q != acc_q);
    code_d = cand_q;
    if (evt_d) acc_d = cand_q;
  end

  always_comb begin
    dec_pos = 2'd0;
    is_pos  = 1'b0;
    is_idle = 1'b0;
    case (code_q)
      4'b0111: begin dec_pos = 2'd0; is_pos = 1'b1; end
      4'b1011: begin dec_pos = 2'd1; is_pos = 1'b1; end
      4'b1101: begin dec_pos = 2'd2; is_pos = 1'b1; end
      4'b1110: begin dec_pos = 2'd3; is_pos = 1'b1; end
      4'b1111: is_idle = 1'b1;
      default: ;
    endcase
    next_last = last_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    last_v_d    = last_v_q;
    streak_d    = streak_q;
    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    step_d      = 1'b0;
    seq_d       = 1'b0;
    code_err_d  = 1'b0;
    if (evt_q) begin
      case (state_q)
        SEARCH: begin
          if (is_pos) begin
            streak_d    = (last_v_q && dec_pos == next_last) ? streak_q + 1'b1 : '0;
            last_d      = dec_pos;
            last_v_d    = 1'b1;
            pos_d       = dec_pos;
            pos_valid_d = 1'b1;
            if (streak_d == STRK_LOCK) state_d = LOCKED;
          end else begin
            code_err_d  = !is_idle;
            pos_valid_d = 1'b0;
            last_v_d    = 1'b0;
            streak_d    = '0;
          end
        end
        LOCKED: begin
          if (is_pos) begin
            pos_d  = dec_pos;
            last_d = dec_pos;
            if (dec_pos == next_last) begin
              step_d = 1'b1;
            end else begin
              seq_d    = 1'b1;
              streak_d = '0;
              state_d  = SEARCH;
            end
          end else begin
            // Idle is a clean stop of the generator, so only a corrupt code is an error.
            code_err_d  = !is_idle;
            state_d     = SEARCH;
            pos_valid_d = 1'b0;
            last_v_d    = 1'b0;
            streak_d    = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (clr_cnt) err_cnt_d = '0;
    else if ((seq_d || code_err_d) && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      cand_q      <= 4'b1111;
      cnt_q       <= '0;
      acc_q       <= 4'b1111;
      evt_q       <= 1'b0;
      code_q      <= 4'b1111;
      state_q     <= SEARCH;
      last_q      <= 2'd0;
      last_v_q    <= 1'b0;
      streak_q    <= '0;
      pos_q       <= 2'd0;
      pos_valid_q <= 1'b0;
      step_q      <= 1'b0;
      seq_q       <= 1'b0;
      code_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      evt_q       <= evt_d;
      code_q      <= code_d;
      state_q     <= state_d;
      last_q      <= last_d;
      last_v_q    <= last_v_d;
      streak_q    <= streak_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      step_q      <= step_d;
      seq_q       <= seq_d;
      code_err_q  <= code_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pos        = pos_q;
  assign pos_valid  = pos_valid_q;
  assign locked     = (state_q == LOCKED);
  assign step_pulse = step_q;
  assign seq_err    = seq_q;
  assign code_err   = code_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_led_flow_monitor.sv
// Directed bench for led_flow_monitor with STABLE_CYCLES=4, LOCK_STEPS=2, ERR_CNT_W=2.
module tb_led_flow_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] led_in;
  logic       clr_cnt;
  logic [1:0] pos;
  logic       pos_valid, locked, step_pulse, seq_err, code_err;
  logic [1:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int step_hi = 0, seq_hi = 0, code_hi = 0, overlap = 0;
  int base_step, base_seq, base_code;

  led_flow_monitor #(.STABLE_CYCLES(4), .LOCK_STEPS(2), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .clr_cnt(clr_cnt),
    .pos(pos), .pos_valid(pos_valid), .locked(locked), .step_pulse(step_pulse),
    .seq_err(seq_err), .code_err(code_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      step_hi = step_hi + int'(step_pulse);
      seq_hi  = seq_hi + int'(seq_err);
      code_hi = code_hi + int'(code_err);
      if (int'(step_pulse) + int'(seq_err) + int'(code_err) > 1) overlap = overlap + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    led_in = v;
    repeat (n) tick();
  endtask

  task automatic snap();
    base_step = step_hi;
    base_seq  = seq_hi;
    base_code = code_hi;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; led_in = 4'b1111; clr_cnt = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if ({pos, pos_valid, locked, step_pulse, seq_err, code_err} !== 7'd0) begin n_err++; $display("FAIL reset_outputs: got %b want 0000000", {pos, pos_valid, locked, step_pulse, seq_err, code_err}); end
    n_vec++; if (err_cnt !== 2'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    drive(4'b1111, 5);
    n_vec++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_event: got pos_valid=%b want 0", pos_valid); end
  endtask

  task automatic test_lock_step();
    snap();
    drive(4'b0111, 7);
    n_vec++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got pos_valid=%b want 0 after 7 edges", pos_valid); end
    tick();
    n_vec++; if ({pos_valid, pos, locked} !== 4'b1000) begin n_err++; $display("FAIL latency_edge7: got {pv,pos,lk}=%b want 1000", {pos_valid, pos, locked}); end
    drive(4'b0111, 2);
    drive(4'b1011, 10);
    n_vec++; if ({pos_valid, pos, locked} !== 4'b1010) begin n_err++; $display("FAIL lock_pos1: got {pv,pos,lk}=%b want 1010", {pos_valid, pos, locked}); end
    drive(4'b1101, 10);
    n_vec++; if ({pos_valid, pos, locked} !== 4'b1101) begin n_err++; $display("FAIL lock_entry: got {pv,pos,lk}=%b want 1101", {pos_valid, pos, locked}); end
    n_vec++; if (step_hi !== base_step) begin n_err++; $display("FAIL lock_no_step_yet: got %0d steps want %0d", step_hi - base_step, 0); end
    drive(4'b1110, 10);
    n_vec++; if ({pos, locked} !== 3'b111 || step_hi !== base_step + 1) begin n_err++; $display("FAIL step_pos3: got pos=%0d lk=%b steps=%0d want pos=3 lk=1 steps=1", pos, locked, step_hi - base_step); end
    drive(4'b0111, 10);
    n_vec++; if ({pos, locked} !== 3'b001 || step_hi !== base_step + 2) begin n_err++; $display("FAIL step_pos0: got pos=%0d lk=%b steps=%0d want pos=0 lk=1 steps=2", pos, locked, step_hi - base_step); end
    n_vec++; if (err_cnt !== 2'd0 || seq_hi !== base_seq || code_hi !== base_code) begin n_err++; $display("FAIL lock_no_errors: got err_cnt=%0d seq=%0d code=%0d want 0 0 0", err_cnt, seq_hi - base_seq, code_hi - base_code); end
  endtask

  task automatic test_glitch();
    drive(4'b1011, 10);
    snap();
    n_vec++; if ({pos, locked} !== 3'b011) begin n_err++; $display("FAIL glitch_setup: got pos=%0d lk=%b want pos=1 lk=1", pos, locked); end
    drive(4'b1101, 3);
    drive(4'b1011, 12);
    n_vec++; if ({pos, pos_valid, locked} !== 4'b0111 || step_hi !== base_step || seq_hi !== base_seq) begin n_err++; $display("FAIL glitch_3clk: got pos=%0d pv=%b lk=%b steps=%0d seq=%0d want 1 1 1 0 0", pos, pos_valid, locked, step_hi - base_step, seq_hi - base_seq); end
    drive(4'b1101, 4);
    drive(4'b1110, 4);
    n_vec++; if (pos !== 2'd2 || step_pulse !== 1'b1) begin n_err++; $display("FAIL glitch_4clk: got pos=%0d step=%b want pos=2 step=1", pos, step_pulse); end
    tick();
    n_vec++; if (step_pulse !== 1'b0) begin n_err++; $display("FAIL step_width: got step=%b want 0 one clock later", step_pulse); end
    drive(4'b1110, 10);
    n_vec++; if (pos !== 2'd3 || step_hi !== base_step + 2 || locked !== 1'b1) begin n_err++; $display("FAIL glitch_follow: got pos=%0d steps=%0d lk=%b want 3 2 1", pos, step_hi - base_step, locked); end
  endtask

  task automatic test_skip();
    drive(4'b0111, 10);
    drive(4'b1011, 10);
    snap();
    drive(4'b1110, 10);
    n_vec++; if (seq_hi !== base_seq + 1 || err_cnt !== 2'd1) begin n_err++; $display("FAIL skip_seq_err: got seq=%0d err_cnt=%0d want 1 1", seq_hi - base_seq, err_cnt); end
    n_vec++; if ({locked, pos, pos_valid} !== 4'b0111) begin n_err++; $display("FAIL skip_state: got {lk,pos,pv}=%b want 0111", {locked, pos, pos_valid}); end
  endtask

  task automatic test_illegal_idle();
    snap();
    drive(4'b0011, 10);
    n_vec++; if (code_hi !== base_code + 1 || err_cnt !== 2'd2 || pos_valid !== 1'b0 || locked !== 1'b0) begin n_err++; $display("FAIL illegal_code: got code=%0d err_cnt=%0d pv=%b lk=%b want 1 2 0 0", code_hi - base_code, err_cnt, pos_valid, locked); end
    drive(4'b0111, 10);
    drive(4'b1011, 10);
    drive(4'b1101, 10);
    n_vec++; if (locked !== 1'b1 || pos !== 2'd2) begin n_err++; $display("FAIL relock: got lk=%b pos=%0d want 1 2", locked, pos); end
    snap();
    drive(4'b1111, 10);
    n_vec++; if ({locked, pos_valid} !== 2'b00 || pos !== 2'd2) begin n_err++; $display("FAIL idle_exit: got lk=%b pv=%b pos=%0d want 0 0 2", locked, pos_valid, pos); end
    n_vec++; if (code_hi !== base_code || seq_hi !== base_seq || err_cnt !== 2'd2) begin n_err++; $display("FAIL idle_no_error: got code=%0d seq=%0d err_cnt=%0d want 0 0 2", code_hi - base_code, seq_hi - base_seq, err_cnt); end
  endtask

  task automatic test_saturate_clear();
    logic [3:0] codes [6];
    logic [1:0] want;
    codes[0] = 4'b0011; codes[1] = 4'b0101; codes[2] = 4'b0011;
    codes[3] = 4'b0101; codes[4] = 4'b0011; codes[5] = 4'b0101;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_vec++; if (err_cnt !== 2'd0) begin n_err++; $display("FAIL clr_cnt: got %0d want 0", err_cnt); end
    for (int i = 0; i < 5; i++) begin
      drive(codes[i], 10);
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_vec++; if (err_cnt !== want) begin n_err++; $display("FAIL sat_code%0d: got err_cnt=%0d want %0d", i, err_cnt, want); end
    end
    drive(codes[5], 7);
    n_vec++; if (code_err !== 1'b0 || err_cnt !== 2'd3) begin n_err++; $display("FAIL clr_pre: got code_err=%b err_cnt=%0d want 0 3", code_err, err_cnt); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_vec++; if (code_err !== 1'b1 || err_cnt !== 2'd0) begin n_err++; $display("FAIL clr_wins: got code_err=%b err_cnt=%0d want 1 0", code_err, err_cnt); end
    drive(codes[5], 3);
    n_vec++; if (err_cnt !== 2'd0) begin n_err++; $display("FAIL clr_hold: got err_cnt=%0d want 0", err_cnt); end
  endtask

  task automatic test_reset_midrun();
    drive(4'b0011, 10);
    drive(4'b0111, 10);
    drive(4'b1011, 10);
    drive(4'b1101, 10);
    n_vec++; if (locked !== 1'b1 || err_cnt !== 2'd1) begin n_err++; $display("FAIL midrun_setup: got lk=%b err_cnt=%0d want 1 1", locked, err_cnt); end
    drive(4'b0111, 2);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({pos, pos_valid, locked, step_pulse, seq_err, code_err, err_cnt} !== 9'd0) begin n_err++; $display("FAIL midrun_reset: got %b want 000000000", {pos, pos_valid, locked, step_pulse, seq_err, code_err, err_cnt}); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_step();
    test_glitch();
    test_skip();
    test_illegal_idle();
    test_saturate_clear();
    test_reset_midrun();
    n_vec++; if (overlap !== 0) begin n_err++; $display("FAIL pulse_overlap: got %0d cycles want 0", overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
